// File: rtl/id_operand_unit.sv
// Decode-stage operand/address block: 32-entry register file with same-cycle
// writeback bypass, destination select, branch/compact-branch/jump targets.
module id_operand_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      inst,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc4,
  input  logic             rd_src,
  input  logic             bc,
  input  logic             wb_en,
  input  logic [4:0]       wb_regnum,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] a_data,
  output logic [WIDTH-1:0] b_data,
  output logic [4:0]       w_regnum,
  output logic [WIDTH-1:0] pc_branch,
  output logic [WIDTH-1:0] jump_addr
);

  logic [WIDTH-1:0] regs [32];
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             wb_live;
  logic [WIDTH-1:0] boff;
  logic [WIDTH-1:0] coff;
  logic             unused_opcode;

  assign rs            = inst[25:21];
  assign rt            = inst[20:16];
  assign wb_live       = wb_en && (wb_regnum != 5'd0);
  assign unused_opcode = ^inst[31:26];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_live) begin
      regs[wb_regnum] <= wb_data;
    end
  end

  // Writeback data wins over storage so decode sees this cycle's result;
  // register 0 is forced to zero regardless of what its entry holds.
  always_comb begin
    a_data = '0;
    b_data = '0;
    if (wb_live && wb_regnum == rs) begin
      a_data = wb_data;
    end else if (rs != 5'd0) begin
      a_data = regs[rs];
    end
    if (wb_live && wb_regnum == rt) begin
      b_data = wb_data;
    end else if (rt != 5'd0) begin
      b_data = regs[rt];
    end
  end

  assign w_regnum = rd_src ? inst[20:16] : inst[15:11];

  assign boff      = {{(WIDTH-18){inst[15]}}, inst[15:0], 2'b00};
  assign coff      = {{(WIDTH-28){inst[25]}}, inst[25:0], 2'b00};
  assign pc_branch = bc ? (pc4 + coff) : (pc + boff);
  assign jump_addr = WIDTH'({pc4[WIDTH-1:WIDTH-4], inst[25:0], 2'b00});

endmodule

// File: tb/tb_id_operand_unit.sv
// Directed self-checking bench for id_operand_unit.
module tb_id_operand_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic [63:0] pc;
  logic [63:0] pc4;
  logic        rd_src;
  logic        bc;
  logic        wb_en;
  logic [4:0]  wb_regnum;
  logic [63:0] wb_data;
  logic [63:0] a_data;
  logic [63:0] b_data;
  logic [4:0]  w_regnum;
  logic [63:0] pc_branch;
  logic [63:0] jump_addr;

  int checks = 0;
  int errors = 0;

  id_operand_unit #(.WIDTH(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .inst      (inst),
    .pc        (pc),
    .pc4       (pc4),
    .rd_src    (rd_src),
    .bc        (bc),
    .wb_en     (wb_en),
    .wb_regnum (wb_regnum),
    .wb_data   (wb_data),
    .a_data    (a_data),
    .b_data    (b_data),
    .w_regnum  (w_regnum),
    .pc_branch (pc_branch),
    .jump_addr (jump_addr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                     input logic [4:0] rd_f);
    return {6'b0, rs_f, rt_f, rd_f, 11'b0};
  endfunction

  // Advance past the next rising edge, then settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    inst      = '0;
    pc        = '0;
    pc4       = '0;
    rd_src    = 1'b0;
    bc        = 1'b0;
    wb_en     = 1'b0;
    wb_regnum = '0;
    wb_data   = '0;

    // Reset sweep: every register reads zero on both ports.
    tick();
    for (int i = 0; i < 32; i++) begin
      inst = mk(5'(i), 5'(31 - i), 5'd0);
      #1;
      check($sformatf("rst_a%0d", i), a_data, 64'd0);
      check($sformatf("rst_b%0d", i), b_data, 64'd0);
    end
    reset = 1'b0;

    // Write R5, visible next cycle from storage.
    inst      = mk(5'd0, 5'd0, 5'd0);
    wb_en     = 1'b1;
    wb_regnum = 5'd5;
    wb_data   = 64'h1122334455667788;
    tick();
    wb_en = 1'b0;
    inst  = mk(5'd5, 5'd0, 5'd0);
    #1;
    check("r5_read", a_data, 64'h1122334455667788);
    check("r5_b_zero", b_data, 64'd0);

    // Register 0: no bypass, no write.
    wb_en     = 1'b1;
    wb_regnum = 5'd0;
    wb_data   = '1;
    inst      = mk(5'd0, 5'd0, 5'd0);
    #1;
    check("r0_same_a", a_data, 64'd0);
    check("r0_same_b", b_data, 64'd0);
    tick();
    check("r0_next_a", a_data, 64'd0);
    wb_en = 1'b0;

    // Bypass: R7=3 stored, then drive 9 with and without enable.
    wb_en     = 1'b1;
    wb_regnum = 5'd7;
    wb_data   = 64'd3;
    tick();
    wb_en   = 1'b0;
    wb_data = 64'd9;
    inst    = mk(5'd7, 5'd7, 5'd0);
    #1;
    check("nobyp_a", a_data, 64'd3);
    check("nobyp_b", b_data, 64'd3);
    wb_en = 1'b1;
    #1;
    check("byp_a", a_data, 64'd9);
    check("byp_b", b_data, 64'd9);
    tick();
    wb_en = 1'b0;
    #1;
    check("r7_stored_a", a_data, 64'd9);
    check("r7_stored_b", b_data, 64'd9);

    // Destination select.
    inst   = mk(5'd0, 5'd4, 5'd12);
    rd_src = 1'b1;
    #1;
    check("wreg_itype", 64'(w_regnum), 64'd4);
    rd_src = 1'b0;
    #1;
    check("wreg_rtype", 64'(w_regnum), 64'd12);

    // Branch targets.
    pc   = 64'h1000;
    pc4  = 64'h1004;
    inst = {16'h0000, 16'hFFFF};
    bc   = 1'b0;
    #1;
    check("br_neg", pc_branch, 64'h0FFC);
    inst = {6'b0, 26'h0000010};
    bc   = 1'b1;
    #1;
    check("cbr_pos", pc_branch, 64'h1044);
    inst = {6'b0, 26'h2000000};
    #1;
    check("cbr_neg", pc_branch, 64'h1004 - 64'h8000000);
    inst = {16'h0000, 16'h7FFF};
    bc   = 1'b0;
    #1;
    check("br_pos", pc_branch, 64'h1000 + 64'h1FFFC);

    // Jump target.
    pc4  = 64'hA000000000000004;
    inst = {6'b0, 26'h3FFFFFF};
    #1;
    check("jump", jump_addr, 64'h00000000AFFFFFFC);

    // Async reset mid-cycle clears stored values without an edge.
    inst = mk(5'd5, 5'd7, 5'd0);
    #1;
    check("pre_rst_a", a_data, 64'h1122334455667788);
    reset = 1'b1;
    #1;
    check("async_rst_a", a_data, 64'd0);
    check("async_rst_b", b_data, 64'd0);

    // Bypass still applies during reset, and the write is ignored.
    wb_en     = 1'b1;
    wb_regnum = 5'd5;
    wb_data   = 64'hDEAD;
    #1;
    check("rst_byp_a", a_data, 64'hDEAD);
    tick();
    wb_en = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_nowrite", a_data, 64'd0);

    // Fresh write after reset on R3; R7 stays cleared.
    wb_en     = 1'b1;
    wb_regnum = 5'd3;
    wb_data   = 64'h0123456789ABCDEF;
    tick();
    wb_en = 1'b0;
    inst  = mk(5'd3, 5'd7, 5'd0);
    #1;
    check("post_rst_r3", a_data, 64'h0123456789ABCDEF);
    check("post_rst_r7", b_data, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
